// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_arb_pkg: shared FSM state type and the width helper for the FIFO write arbiter
package fifo_arb_pkg;

    typedef enum logic {ST_IDLE, ST_BURST} state_t;

    // Bits needed to index n items (n >= 2), or to count 0..n-1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: producer handshakes plus the FIFO write port seen by the arbiter
//   i_req_valid/i_req_data/o_req_ready : per-producer valid/ready, producer k at [k*DATA_WIDTH +: DATA_WIDTH]
//   i_fifo_full/o_fifo_wen/o_fifo_wdata : FIFO write port, wdata = {source id, payload}
//   o_grant_id/o_busy                   : current owner or IDLE winner, and burst-in-progress flag
//   master = arbiter side, slave = producers/FIFO side
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ID_WIDTH   = fifo_arb_pkg::clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]            i_req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data;
    logic [NUM_REQ-1:0]            o_req_ready;
    logic                          i_fifo_full;
    logic                          o_fifo_wen;
    logic [ID_WIDTH+DATA_WIDTH-1:0] o_fifo_wdata;
    logic [ID_WIDTH-1:0]           o_grant_id;
    logic                          o_busy;

    modport master (
        input  i_req_valid, i_req_data, i_fifo_full,
        output o_req_ready, o_fifo_wen, o_fifo_wdata, o_grant_id, o_busy
    );

    modport slave (
        output i_req_valid, i_req_data, i_fifo_full,
        input  o_req_ready, o_fifo_wen, o_fifo_wdata, o_grant_id, o_busy
    );
endinterface

// File: rtl/fifo_wr_arbiter_rr_priority_pick.sv
// rr_priority_pick: first set request scanning i_ptr, i_ptr+1, ... (mod NUM_REQ), combinational
//   i_req    : request vector
//   i_ptr    : highest-priority index (must be < NUM_REQ)
//   o_found  : any request set
//   o_winner : chosen index (0 when none)
module rr_priority_pick #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = fifo_arb_pkg::clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  i_req,
    input  logic [ID_WIDTH-1:0] i_ptr,
    output logic                o_found,
    output logic [ID_WIDTH-1:0] o_winner
);
    // Explicit wrap keeps non-power-of-2 NUM_REQ correct without a divider.
    function automatic int wrap(input int v);
        return (v >= NUM_REQ) ? v - NUM_REQ : v;
    endfunction

    // Scan from the lowest priority upward so the closest-to-ptr request is written last.
    always_comb begin
        o_found  = |i_req;
        o_winner = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (i_req[wrap(int'(i_ptr) + i)]) o_winner = ID_WIDTH'(wrap(int'(i_ptr) + i));
    end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port among NUM_REQ producers in bursts
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : producer valid/ready/data in, FIFO full in, FIFO wen/wdata, grant id and busy out
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_MAX  = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    fifo_wr_arbiter_if.master bus
);
    localparam int ID_WIDTH  = clog2(NUM_REQ);
    localparam int CNT_WIDTH = clog2(BURST_MAX + 1);

    state_t               state;
    logic [ID_WIDTH-1:0]  owner, ptr, winner, gid;
    logic [CNT_WIDTH-1:0] cnt;
    logic [NUM_REQ-1:0]   ready;
    logic                 found, burst, last;

    rr_priority_pick #(.NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH)) u_pick (
        .i_req    (bus.i_req_valid),
        .i_ptr    (ptr),
        .o_found  (found),
        .o_winner (winner)
    );

    function automatic logic [ID_WIDTH-1:0] inc(input logic [ID_WIDTH-1:0] x);
        return (int'(x) == NUM_REQ - 1) ? '0 : x + 1'b1;
    endfunction

    assign burst = state == ST_BURST;
    assign gid   = burst ? owner : (found ? winner : '0);
    assign last  = int'(cnt) + 1 == BURST_MAX;

    // In BURST the owner is offered ready even if it has dropped valid; that cycle is the bubble.
    always_comb begin
        ready = '0;
        if (!bus.i_fifo_full && (burst || found)) ready[gid] = 1'b1;
    end

    assign bus.o_req_ready  = ready;
    assign bus.o_fifo_wen   = |(bus.i_req_valid & ready);
    assign bus.o_fifo_wdata = {gid, bus.i_req_data[int'(gid)*DATA_WIDTH +: DATA_WIDTH]};
    assign bus.o_grant_id   = gid;
    assign bus.o_busy       = burst;

    // A full FIFO freezes everything: grant, count and pointer all hold.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
            owner <= '0;
            cnt   <= '0;
            ptr   <= '0;
        end else if (!bus.i_fifo_full) begin
            if (!burst) begin
                if (found) begin
                    owner <= winner;
                    if (BURST_MAX == 1) begin
                        ptr <= inc(winner);
                        cnt <= '0;
                    end else begin
                        state <= ST_BURST;
                        cnt   <= CNT_WIDTH'(1);
                    end
                end
            end else if (!bus.i_req_valid[owner] || last) begin
                state <= ST_IDLE;
                ptr   <= inc(owner);
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed-vector bench for fifo_wr_arbiter (BURST_MAX=4 and BURST_MAX=1 instances)
module tb_fifo_wr_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        full = 1'b0;
    logic        hold = 1'b0;
    logic        sel = 1'b0;
    logic [3:0]  valid = '0;
    logic [31:0] data = '0;
    int          rem[4];
    logic [7:0]  cur[4];
    logic [3:0]  s_ready, hs;
    logic        s_wen, s_busy;
    logic [1:0]  s_gid;
    logic [9:0]  s_wdata;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) ifa ();
    fifo_wr_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) ifb ();

    assign ifa.i_req_valid = valid;
    assign ifa.i_req_data  = data;
    assign ifa.i_fifo_full = full;
    assign ifb.i_req_valid = valid;
    assign ifb.i_req_data  = data;
    assign ifb.i_fifo_full = full;

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .BURST_MAX(4)) dut_a (.i_clk(clk), .i_rst_n(rst_n), .bus(ifa));
    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .BURST_MAX(1)) dut_b (.i_clk(clk), .i_rst_n(rst_n), .bus(ifb));

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        for (int k = 0; k < 4; k++) begin
            valid[k]       = !hold && rem[k] > 0;
            data[k*8 +: 8] = cur[k];
        end
    endtask

    // Sample the selected DUT mid-cycle, then advance producers on the handshake seen.
    task automatic cyc();
        @(negedge clk);
        s_ready = sel ? ifb.o_req_ready  : ifa.o_req_ready;
        s_wen   = sel ? ifb.o_fifo_wen   : ifa.o_fifo_wen;
        s_wdata = sel ? ifb.o_fifo_wdata : ifa.o_fifo_wdata;
        s_gid   = sel ? ifb.o_grant_id   : ifa.o_grant_id;
        s_busy  = sel ? ifb.o_busy       : ifa.o_busy;
        hs      = valid & s_ready;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++)
            if (hs[k]) begin
                rem[k]--;
                cur[k]++;
            end
        drive();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        hold  = 1'b0;
        full  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            rem[k] = 0;
            cur[k] = 8'(k * 16);
        end
        drive();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy_a", 16'(ifa.o_busy), 16'h0);
        chk("rst_gid_a", 16'(ifa.o_grant_id), 16'h0);
        chk("rst_wen_b", 16'(ifb.o_fifo_wen), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [5:0] bexp;
        // T1: producer 2 alone, six words, burst boundary after the fourth
        sel = 1'b0;
        do_reset();
        rem[2] = 6;
        cur[2] = 8'hA0;
        drive();
        bexp = 6'b101110;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk($sformatf("t1_wen%0d", i), 16'(s_wen), 16'h1);
            chk($sformatf("t1_wdata%0d", i), 16'(s_wdata), 16'(10'h200 + 10'(8'hA0 + i)));
            chk($sformatf("t1_busy%0d", i), 16'(s_busy), 16'(bexp[i]));
        end
        cyc();
        chk("t1_done_wen", 16'(s_wen), 16'h0);

        // T2: BURST_MAX=1, all four valid -> strict rotation
        sel = 1'b1;
        do_reset();
        for (int k = 0; k < 4; k++) rem[k] = 100;
        drive();
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk($sformatf("t2_gid%0d", i), 16'(s_gid), 16'(i % 4));
            chk($sformatf("t2_wdata%0d", i), 16'(s_wdata), 16'((i % 4) * 256 + (i % 4) * 16 + i / 4));
            chk($sformatf("t2_wen%0d", i), 16'(s_wen), 16'h1);
        end

        // T3: producers 0 and 1 alternate in bursts of four with no bubble
        sel = 1'b0;
        do_reset();
        rem[0] = 100;
        rem[1] = 100;
        drive();
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk($sformatf("t3_gid%0d", i), 16'(s_gid), 16'((i / 4) % 2));
            chk($sformatf("t3_wen%0d", i), 16'(s_wen), 16'h1);
        end

        // T4: full stalls producer 1's burst for three cycles; producer 3 waits
        do_reset();
        rem[1] = 4;
        cur[1] = 8'h50;
        rem[3] = 1;
        cur[3] = 8'h70;
        drive();
        cyc();
        chk("t4_w0", 16'(s_wdata), 16'h150);
        cyc();
        chk("t4_w1", 16'(s_wdata), 16'h151);
        full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk($sformatf("t4_full_wen%0d", i), 16'(s_wen), 16'h0);
            chk($sformatf("t4_full_rdy%0d", i), 16'(s_ready), 16'h0);
            chk($sformatf("t4_full_gid%0d", i), 16'(s_gid), 16'h1);
        end
        full = 1'b0;
        cyc();
        chk("t4_w2", 16'(s_wdata), 16'h152);
        cyc();
        chk("t4_w3", 16'(s_wdata), 16'h153);
        cyc();
        chk("t4_next_gid", 16'(s_gid), 16'h3);
        chk("t4_next_wdata", 16'(s_wdata), 16'h370);

        // T5: owner drops valid after one word -> one bubble, then ptr=1 picks producer 3
        do_reset();
        rem[0] = 1;
        cur[0] = 8'h11;
        rem[3] = 2;
        cur[3] = 8'h33;
        drive();
        cyc();
        chk("t5_w0", 16'(s_wdata), 16'h011);
        cyc();
        chk("t5_bubble_wen", 16'(s_wen), 16'h0);
        chk("t5_bubble_busy", 16'(s_busy), 16'h1);
        cyc();
        chk("t5_next_gid", 16'(s_gid), 16'h3);
        chk("t5_next_wdata", 16'(s_wdata), 16'h333);

        // T6: reset in the middle of producer 2's burst
        do_reset();
        for (int k = 0; k < 4; k++) rem[k] = 100;
        drive();
        for (int i = 0; i < 10; i++) cyc();
        chk("t6_pre_gid", 16'(s_gid), 16'h2);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", 16'(ifa.o_busy), 16'h0);
        hold = 1'b1;
        drive();
        #1;
        chk("t6_rst_gid", 16'(ifa.o_grant_id), 16'h0);
        chk("t6_rst_rdy", 16'(ifa.o_req_ready), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        hold = 1'b0;
        drive();
        cyc();
        chk("t6_after_gid", 16'(s_gid), 16'h0);
        chk("t6_after_wdata", 16'(s_wdata), 16'h004);
        cyc();
        chk("t6_after_w1", 16'(s_wdata), 16'h005);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
